button_counter: RTL and testbench

Parametrised successor to the single-button LED counter: two active-high push buttons drive an up/down event counter whose low bits feed the board LEDs. Each button is synchronised to `clk`, debounced by a per-button stability counter, and edge-detected so one physical press produces exactly one count step. Counter width, LED width, debounce interval and wrap/saturate mode are parameters; one-cycle press pulses are exported for other blocks.

---
 rtl/button_counter.sv | 104 ++++++++++
 tb/tb_button_counter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_counter.sv
// button_counter: two debounced push buttons drive an up/down event counter; LEDs show its LSBs.
// Latency: raw press to count/pulse update is 2 + DEBOUNCE clk edges (synchroniser + debounce).
// Backpressure: none; at most one event per button per 2*DEBOUNCE cycles, faster activity is filtered.
//
// Ports:
//   clk        - sole clock, all state on rising edge
//   rst_n      - synchronous active-low reset
//   buttons    - raw asynchronous buttons, [0] = up, [1] = down, active-high
//   count      - registered counter value
//   led        - count[LED_WIDTH-1:0]
//   up_pulse   - one-cycle registered pulse per accepted up press
//   down_pulse - one-cycle registered pulse per accepted down press
module button_counter #(
  parameter int WIDTH     = 6,
  parameter int LED_WIDTH = 4,
  parameter int DEBOUNCE  = 250000,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           buttons,
  output logic [WIDTH-1:0]     count,
  output logic [LED_WIDTH-1:0] led,
  output logic                 up_pulse,
  output logic                 down_pulse
);

  // $clog2(1) is 0, so a single-cycle debounce still gets a 1-bit counter.
  localparam int              DW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0]   DMAX = DW'(DEBOUNCE - 1);
  localparam logic [WIDTH-1:0] CMAX = '1;

  logic [1:0]          meta_q;
  logic [1:0]          sync_q;
  logic [1:0]          stable_q, stable_d;
  logic [1:0][DW-1:0]  dcnt_q, dcnt_d;
  logic [1:0]          press;
  logic [WIDTH-1:0]    count_q, count_d;
  logic                up_q, down_q;

  // Debounce: a new synchronised level must persist for DEBOUNCE consecutive
  // cycles; any return to the accepted level restarts the interval.
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = dcnt_q;
    for (int b = 0; b < 2; b++) begin
      if (sync_q[b] == stable_q[b]) begin
        dcnt_d[b] = '0;
      end else if (dcnt_q[b] == DMAX) begin
        stable_d[b] = sync_q[b];
        dcnt_d[b]   = '0;
      end else begin
        dcnt_d[b] = dcnt_q[b] + 1'b1;
      end
    end
  end

  // Events are taken from the next accepted level so the count moves on the
  // same edge that accepts the press.
  assign press = stable_d & ~stable_q;

  always_comb begin
    count_d = count_q;
    unique case (press)
      2'b01: begin
        if (!(SATURATE != 0 && count_q == CMAX)) begin
          count_d = count_q + 1'b1;
        end
      end
      2'b10: begin
        if (!(SATURATE != 0 && count_q == '0)) begin
          count_d = count_q - 1'b1;
        end
      end
      default: count_d = count_q; // idle, or both presses cancel
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      dcnt_q   <= '0;
      count_q  <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
    end else begin
      meta_q   <= buttons;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      count_q  <= count_d;
      up_q     <= press[0];
      down_q   <= press[1];
    end
  end

  assign count      = count_q;
  assign led        = count_q[LED_WIDTH-1:0];
  assign up_pulse   = up_q;
  assign down_pulse = down_q;

endmodule

// File: tb/tb_button_counter.sv
// tb_button_counter: checks a wrapping and a saturating button_counter side by side.
// Latency: expects count/pulse 2 + D edges after a raw level change.
// Backpressure: n/a; inputs change on falling edges, outputs sampled on falling edges.
module tb_button_counter;

  localparam int W   = 6;
  localparam int LW  = 4;
  localparam int D   = 4;
  localparam int MOD = 1 << W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    buttons = 2'b00;
  logic [W-1:0]  cnt_w, cnt_s;
  logic [LW-1:0] led_w, led_s;
  logic          upw, dnw, ups, dns;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  button_counter #(.WIDTH(W), .LED_WIDTH(LW), .DEBOUNCE(D), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .buttons(buttons),
    .count(cnt_w), .led(led_w), .up_pulse(upw), .down_pulse(dnw)
  );

  button_counter #(.WIDTH(W), .LED_WIDTH(LW), .DEBOUNCE(D), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .buttons(buttons),
    .count(cnt_s), .led(led_s), .up_pulse(ups), .down_pulse(dns)
  );

  // Reference model: a level is accepted once the synchronised button has
  // disagreed with the accepted level for the whole last D cycles.
  bit [1:0] m_s1;
  bit [1:0] m_hist[$];
  bit [1:0] m_stab;
  bit [1:0] m_pulse;
  int       m_cw, m_cs;

  always @(posedge clk) begin
    bit [1:0] rise;
    bit       all_diff;
    if (!rst_n) begin
      m_s1 = 2'b00; m_hist.delete(); m_stab = 2'b00; m_pulse = 2'b00; m_cw = 0; m_cs = 0;
    end else begin
      rise = 2'b00;
      if (m_hist.size() == D) begin
        for (int b = 0; b < 2; b++) begin
          all_diff = 1'b1;
          foreach (m_hist[i]) if (m_hist[i][b] == m_stab[b]) all_diff = 1'b0;
          if (all_diff) begin
            rise[b]   = ~m_stab[b];
            m_stab[b] = ~m_stab[b];
          end
        end
      end
      m_hist.push_back(m_s1);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      m_s1    = buttons;
      m_pulse = rise;
      if (rise == 2'b01) begin
        m_cw = (m_cw + 1) % MOD;
        m_cs = (m_cs == MOD - 1) ? MOD - 1 : m_cs + 1;
      end else if (rise == 2'b10) begin
        m_cw = (m_cw + MOD - 1) % MOD;
        m_cs = (m_cs == 0) ? 0 : m_cs - 1;
      end
    end
  end

  // Pulse tallies, so press sequences can be checked for exactly one event each.
  int t_upw = 0, t_dnw = 0, t_ups = 0, t_dns = 0;
  always @(negedge clk) begin
    if (upw === 1'b1) t_upw++;
    if (dnw === 1'b1) t_dnw++;
    if (ups === 1'b1) t_ups++;
    if (dns === 1'b1) t_dns++;
  end

  task automatic do_reset();
    buttons = 2'b00;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  task automatic press(input logic [1:0] which);
    buttons = which;
    repeat (8) @(negedge clk);
    buttons = 2'b00;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    buttons = 2'b11;
    rst_n   = 1'b0;
    @(negedge clk);
    n_chk++; if (cnt_w !== '0) $display("FAIL reset_cnt_w: got %0d expected 0", cnt_w); else n_pass++;
    n_chk++; if (led_w !== '0) $display("FAIL reset_led_w: got %0d expected 0", led_w); else n_pass++;
    n_chk++; if ({upw, dnw, ups, dns} !== 4'b0) $display("FAIL reset_pulses: got %b expected 0000", {upw, dnw, ups, dns}); else n_pass++;
    n_chk++; if (cnt_s !== '0) $display("FAIL reset_cnt_s: got %0d expected 0", cnt_s); else n_pass++;
    rst_n   = 1'b1;
    buttons = 2'b00;
    repeat (10) @(negedge clk);
    n_chk++; if (cnt_w !== '0 || led_w !== '0) $display("FAIL reset_idle: got %0d/%0d expected 0/0", cnt_w, led_w); else n_pass++;
    n_chk++; if (t_upw + t_dnw + t_ups + t_dns != 0) $display("FAIL reset_no_pulse: got %0d pulses expected 0", t_upw + t_dnw + t_ups + t_dns); else n_pass++;
  endtask

  task automatic test_single_press();
    do_reset();
    buttons = 2'b01;
    repeat (5) @(negedge clk); // after edge 4
    n_chk++; if (cnt_w !== 6'd0 || upw !== 1'b0) $display("FAIL press_early: got cnt %0d pulse %b expected 0 0", cnt_w, upw); else n_pass++;
    @(negedge clk);            // after edge 5
    n_chk++; if (cnt_w !== 6'd1) $display("FAIL press_cnt: got %0d expected 1", cnt_w); else n_pass++;
    n_chk++; if (upw !== 1'b1) $display("FAIL press_pulse: got %b expected 1", upw); else n_pass++;
    n_chk++; if (led_w !== 4'd1) $display("FAIL press_led: got %0d expected 1", led_w); else n_pass++;
    n_chk++; if (cnt_w !== W'(m_cw) || upw !== m_pulse[0]) $display("FAIL press_model: got %0d/%b expected %0d/%b", cnt_w, upw, m_cw, m_pulse[0]); else n_pass++;
    @(negedge clk);            // after edge 6
    n_chk++; if (upw !== 1'b0) $display("FAIL press_pulse_end: got %b expected 0", upw); else n_pass++;
    repeat (6) @(negedge clk);
    n_chk++; if (cnt_w !== 6'd1) $display("FAIL press_hold: got %0d expected 1", cnt_w); else n_pass++;
    buttons = 2'b00;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_bounce();
    int up0;
    do_reset();
    up0 = t_upw;
    buttons = 2'b01; @(negedge clk);
    buttons = 2'b00; @(negedge clk);
    buttons = 2'b01; @(negedge clk);
    buttons = 2'b00;
    repeat (10) @(negedge clk);
    n_chk++; if (cnt_w !== 6'd0) $display("FAIL bounce_cnt: got %0d expected 0", cnt_w); else n_pass++;
    n_chk++; if (t_upw != up0) $display("FAIL bounce_pulse: got %0d pulses expected 0", t_upw - up0); else n_pass++;
    buttons = 2'b01;
    repeat (10) @(negedge clk);
    n_chk++; if (cnt_w !== 6'd1) $display("FAIL bounce_hold_cnt: got %0d expected 1", cnt_w); else n_pass++;
    n_chk++; if (t_upw != up0 + 1) $display("FAIL bounce_hold_pulse: got %0d pulses expected 1", t_upw - up0); else n_pass++;
    buttons = 2'b00;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (64) press(2'b01);
    n_chk++; if (cnt_w !== 6'd0 || led_w !== 4'd0) $display("FAIL wrap_up: got %0d/%0d expected 0/0", cnt_w, led_w); else n_pass++;
    n_chk++; if (cnt_s !== 6'd63) $display("FAIL wrap_sat_top: got %0d expected 63", cnt_s); else n_pass++;
    press(2'b10);
    n_chk++; if (cnt_w !== 6'd63) $display("FAIL wrap_down_cnt: got %0d expected 63", cnt_w); else n_pass++;
    n_chk++; if (led_w !== 4'hF) $display("FAIL wrap_down_led: got %0h expected f", led_w); else n_pass++;
    n_chk++; if (cnt_s !== 6'd62 || cnt_s !== W'(m_cs)) $display("FAIL wrap_sat_down: got %0d expected 62 (model %0d)", cnt_s, m_cs); else n_pass++;
  endtask

  task automatic test_saturate();
    int dn0;
    do_reset();
    dn0 = t_dns;
    press(2'b10);
    n_chk++; if (cnt_s !== 6'd0) $display("FAIL sat_floor: got %0d expected 0", cnt_s); else n_pass++;
    n_chk++; if (t_dns != dn0 + 1) $display("FAIL sat_floor_pulse: got %0d pulses expected 1", t_dns - dn0); else n_pass++;
    n_chk++; if (cnt_w !== 6'd63) $display("FAIL sat_wrap_under: got %0d expected 63", cnt_w); else n_pass++;
    repeat (70) press(2'b01);
    n_chk++; if (cnt_s !== 6'd63) $display("FAIL sat_ceiling: got %0d expected 63", cnt_s); else n_pass++;
    n_chk++; if (cnt_w !== 6'd5 || cnt_w !== W'(m_cw)) $display("FAIL sat_wrap_run: got %0d expected 5 (model %0d)", cnt_w, m_cw); else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (5) press(2'b01);
    n_chk++; if (cnt_w !== 6'd5) $display("FAIL simul_pre: got %0d expected 5", cnt_w); else n_pass++;
    buttons = 2'b11;
    repeat (6) @(negedge clk); // after edge 5
    n_chk++; if ({upw, dnw, ups, dns} !== 4'b1111) $display("FAIL simul_pulses: got %b expected 1111", {upw, dnw, ups, dns}); else n_pass++;
    n_chk++; if (cnt_w !== 6'd5 || cnt_s !== 6'd5) $display("FAIL simul_cnt: got %0d/%0d expected 5/5", cnt_w, cnt_s); else n_pass++;
    @(negedge clk);
    n_chk++; if ({upw, dnw, ups, dns} !== 4'b0000) $display("FAIL simul_pulse_end: got %b expected 0000", {upw, dnw, ups, dns}); else n_pass++;
    buttons = 2'b00;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_debounce();
    int up0;
    do_reset();
    up0 = t_upw;
    buttons = 2'b01;
    repeat (2) @(negedge clk);
    rst_n   = 1'b0;
    buttons = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_chk++; if (cnt_w !== 6'd0) $display("FAIL middeb_cnt: got %0d expected 0", cnt_w); else n_pass++;
    n_chk++; if (t_upw != up0) $display("FAIL middeb_pulse: got %0d pulses expected 0", t_upw - up0); else n_pass++;
  endtask

  task automatic test_held_through_reset();
    do_reset();
    buttons = 2'b01;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);            // after reset edge r
    rst_n = 1'b1;
    repeat (5) @(negedge clk); // after edge r+5
    n_chk++; if (cnt_w !== 6'd0) $display("FAIL held_early: got %0d expected 0", cnt_w); else n_pass++;
    @(negedge clk);            // after edge r+6
    n_chk++; if (cnt_w !== 6'd1 || upw !== 1'b1) $display("FAIL held_count: got %0d/%b expected 1/1", cnt_w, upw); else n_pass++;
    repeat (8) @(negedge clk);
    n_chk++; if (cnt_w !== 6'd1) $display("FAIL held_once: got %0d expected 1", cnt_w); else n_pass++;
    buttons = 2'b00;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    int hold;
    int errs;
    do_reset();
    hold = 0;
    errs = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold == 0) begin
        buttons = 2'($urandom_range(0, 3));
        hold    = $urandom_range(1, 12);
      end
      hold--;
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
      n_chk++;
      if (cnt_w !== W'(m_cw) || cnt_s !== W'(m_cs) || led_w !== LW'(m_cw) || led_s !== LW'(m_cs) ||
          {dnw, upw} !== m_pulse || {dns, ups} !== m_pulse) begin
        if (errs < 10)
          $display("FAIL random@%0d: got w=%0d s=%0d pw=%b%b ps=%b%b expected w=%0d s=%0d p=%b",
                   cyc, cnt_w, cnt_s, dnw, upw, dns, ups, m_cw, m_cs, m_pulse);
        errs++;
      end else begin
        n_pass++;
      end
    end
    rst_n   = 1'b1;
    buttons = 2'b00;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_wrap();
    test_saturate();
    test_simultaneous();
    test_reset_mid_debounce();
    test_held_through_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
